// File: rtl/tt_bin_clock_set_ctrl_if.sv
// rtl/tt_bin_clock_set_ctrl_if.sv - Board-pin / clock-core signal bundle for the time-set front-end
// Purpose: groups the raw pushbutton inputs and the clock-core drive outputs.
// Signals:
//   btn_set_i, btn_dir_i, btn_hour_i, btn_min_i, btn_sec_i : raw board inputs
//   time_set_o, id_switch_o                                 : level outputs to the clock core
//   hour_id_o, minute_id_o, seconds_id_o                    : one-cycle step strobes
// Modports: master = board/stimulus side, slave = the set controller.
interface tt_bin_clock_set_ctrl_if;
  logic btn_set_i;
  logic btn_dir_i;
  logic btn_hour_i;
  logic btn_min_i;
  logic btn_sec_i;
  logic time_set_o;
  logic id_switch_o;
  logic hour_id_o;
  logic minute_id_o;
  logic seconds_id_o;

  modport master (
    output btn_set_i, btn_dir_i, btn_hour_i, btn_min_i, btn_sec_i,
    input  time_set_o, id_switch_o, hour_id_o, minute_id_o, seconds_id_o
  );

  modport slave (
    input  btn_set_i, btn_dir_i, btn_hour_i, btn_min_i, btn_sec_i,
    output time_set_o, id_switch_o, hour_id_o, minute_id_o, seconds_id_o
  );
endinterface

// File: rtl/tt_bin_clock_set_ctrl.sv
// rtl/tt_bin_clock_set_ctrl.sv - Debounced time-set front-end with auto-repeating step strobes
// Purpose: synchronises and debounces the set/direction/step buttons, toggles set mode,
//   and issues one-cycle hour/minute/seconds step pulses with press-and-hold auto-repeat.
// Ports:
//   clk_i   : system clock (100 Hz)
//   reset_i : asynchronous active-high reset
//   bus     : slave side of tt_bin_clock_set_ctrl_if (raw buttons in, set level/strobes out)
module tt_bin_clock_set_ctrl #(
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int REPEAT_DELAY    = 50,
  parameter int REPEAT_PERIOD   = 10,
  parameter int CNT_W           = 8
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  tt_bin_clock_set_ctrl_if.slave  bus
);

  // Bit order of the conditioned input vectors: {sec, min, hour, dir, set}
  localparam int B_SET = 0;
  localparam int B_DIR = 1;

  localparam logic [CNT_W-1:0] DEB_LIM = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LIM  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LIM  = CNT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  logic [4:0]       raw;
  logic [4:0]       sync1_q, sync1_d;
  logic [4:0]       sync2_q, sync2_d;
  logic [4:0]       deb_q, deb_d;
  logic [CNT_W-1:0] dcnt_q [5];
  logic [CNT_W-1:0] dcnt_d [5];
  logic             set_prev_q, set_prev_d;
  logic             time_set_q, time_set_d;
  logic             id_switch_q, id_switch_d;
  state_t           state_q, state_d;
  logic [2:0]       sel_q, sel_d;      // latched step button, one-hot {sec, min, hour}
  logic [2:0]       pulse_q, pulse_d;  // registered strobes, one-hot {sec, min, hour}
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic [2:0]       step;
  logic [CNT_W-1:0] rlim;

  assign raw  = {bus.btn_sec_i, bus.btn_min_i, bus.btn_hour_i, bus.btn_dir_i, bus.btn_set_i};
  assign step = deb_q[4:2];
  assign rlim = (state_q == DELAY) ? RD_LIM : RP_LIM;

  always_comb begin
    sync1_d     = raw;
    sync2_d     = sync1_q;
    deb_d       = deb_q;
    dcnt_d      = dcnt_q;
    set_prev_d  = deb_q[B_SET];
    id_switch_d = id_switch_q;
    state_d     = state_q;
    sel_d       = sel_q;
    pulse_d     = 3'b000;
    rcnt_d      = rcnt_q;

    // The counter holds how many consecutive earlier samples differed; the level is
    // accepted on the sample that makes it DEBOUNCE_CYCLES in a row.
    for (int i = 0; i < 5; i++) begin
      if (sync2_q[i] == deb_q[i]) begin
        dcnt_d[i] = '0;
      end else if (dcnt_q[i] == DEB_LIM) begin
        deb_d[i]  = sync2_q[i];
        dcnt_d[i] = '0;
      end else if (dcnt_q[i] != '1) begin
        dcnt_d[i] = dcnt_q[i] + 1'b1;
      end
    end

    // Toggle one edge after the debounced set level rises.
    time_set_d = time_set_q ^ (deb_q[B_SET] & ~set_prev_q);

    case (state_q)
      IDLE: begin
        id_switch_d = deb_q[B_DIR];
        // time_set_d is checked too so a strobe never coincides with set mode turning off.
        if (time_set_q && time_set_d && (step != 3'b000)) begin
          if (step[2])      sel_d = 3'b100;
          else if (step[1]) sel_d = 3'b010;
          else              sel_d = 3'b001;
          pulse_d = sel_d;
          rcnt_d  = '0;
          state_d = DELAY;
        end
      end
      DELAY, REPEAT: begin
        // Exit takes priority over a due pulse so nothing fires on the exit edge.
        if (!time_set_d || ((step & sel_q) == 3'b000)) begin
          state_d = IDLE;
          rcnt_d  = '0;
        end else if (rcnt_q == rlim) begin
          pulse_d = sel_q;
          rcnt_d  = '0;
          state_d = REPEAT;
        end else if (rcnt_q != '1) begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      deb_q       <= '0;
      for (int i = 0; i < 5; i++) dcnt_q[i] <= '0;
      set_prev_q  <= 1'b0;
      time_set_q  <= 1'b0;
      id_switch_q <= 1'b0;
      state_q     <= IDLE;
      sel_q       <= 3'b000;
      pulse_q     <= 3'b000;
      rcnt_q      <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      deb_q       <= deb_d;
      for (int i = 0; i < 5; i++) dcnt_q[i] <= dcnt_d[i];
      set_prev_q  <= set_prev_d;
      time_set_q  <= time_set_d;
      id_switch_q <= id_switch_d;
      state_q     <= state_d;
      sel_q       <= sel_d;
      pulse_q     <= pulse_d;
      rcnt_q      <= rcnt_d;
    end
  end

  assign bus.time_set_o   = time_set_q;
  assign bus.id_switch_o  = id_switch_q;
  assign bus.hour_id_o    = pulse_q[0];
  assign bus.minute_id_o  = pulse_q[1];
  assign bus.seconds_id_o = pulse_q[2];

endmodule

// File: tb/tb_tt_bin_clock_set_ctrl.sv
// tb/tb_tt_bin_clock_set_ctrl.sv - Self-checking bench for tt_bin_clock_set_ctrl
module tb_tt_bin_clock_set_ctrl;

  localparam int D  = 3;
  localparam int RD = 50;
  localparam int RP = 10;

  logic clk;
  logic reset_i;
  int   checks;
  int   failures;

  tt_bin_clock_set_ctrl_if bus ();

  tt_bin_clock_set_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
    .CNT_W          (8)
  ) dut (
    .clk_i  (clk),
    .reset_i(reset_i),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: raw samples by edge index, debounce by sliding window, bursts by edge arithmetic.
  logic [4:0] raw_at [0:16383];
  int         n_e;
  int         last_acc [5];
  logic [4:0] m_deb;
  logic       m_ts, m_dir, m_rose, m_active;
  int         m_s, m_lat;
  logic [2:0] m_pulse;

  task automatic model_reset();
    n_e = 0; m_deb = '0; m_ts = 0; m_dir = 0; m_rose = 0; m_active = 0;
    m_s = 0; m_lat = 2; m_pulse = '0;
    for (int i = 0; i < 5; i++) last_acc[i] = -1;
    raw_at[0] = '0; raw_at[1] = '0;
  endtask

  task automatic model_step();
    logic [4:0] nd;
    logic       ts_new, ok;
    int         dd;
    raw_at[n_e + 2] = {bus.btn_sec_i, bus.btn_min_i, bus.btn_hour_i, bus.btn_dir_i, bus.btn_set_i};
    nd = m_deb;
    for (int i = 0; i < 5; i++) begin
      ok = (n_e - D + 1 > last_acc[i]);
      for (int k = 0; k < D; k++) if (ok) if (raw_at[n_e - k][i] == m_deb[i]) ok = 0;
      if (ok) begin nd[i] = ~m_deb[i]; last_acc[i] = n_e; end
    end
    ts_new  = m_ts ^ m_rose;
    m_pulse = '0;
    if (m_active) begin
      if (!ts_new || !m_deb[m_lat]) m_active = 0;
      else begin
        dd = n_e - m_s;
        if (dd == RD || (dd > RD && (dd - RD) % RP == 0)) m_pulse[m_lat - 2] = 1'b1;
      end
    end else begin
      m_dir = m_deb[1];
      if (m_ts && ts_new && (m_deb[4:2] != 3'b000)) begin
        m_active = 1; m_s = n_e;
        m_lat = m_deb[4] ? 4 : (m_deb[3] ? 3 : 2);
        m_pulse[m_lat - 2] = 1'b1;
      end
    end
    m_rose = nd[0] & ~m_deb[0];
    m_deb  = nd;
    m_ts   = ts_new;
    n_e++;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_i) model_reset(); else model_step();
    #1;
  endtask

  function automatic logic [4:0] dut_out();
    return {bus.time_set_o, bus.id_switch_o, bus.hour_id_o, bus.minute_id_o, bus.seconds_id_o};
  endfunction

  function automatic logic [4:0] exp_out();
    return {m_ts, m_dir, m_pulse[0], m_pulse[1], m_pulse[2]};
  endfunction

  task automatic set_buttons(input logic s, input logic d, input logic h, input logic m, input logic c);
    bus.btn_set_i = s; bus.btn_dir_i = d; bus.btn_hour_i = h; bus.btn_min_i = m; bus.btn_sec_i = c;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    set_buttons(0, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (dut_out() !== 5'b00000) begin failures++; $display("FAIL reset_hold got=%b exp=00000", dut_out()); end
    end
    #4 reset_i = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++;
      if (dut_out() !== 5'b00000 || dut_out() !== exp_out())
        begin failures++; $display("FAIL reset_idle k=%0d got=%b exp=%b", k, dut_out(), exp_out()); end
    end
  endtask

  task automatic test_set_toggle();
    int first_on = -1;
    int first_off = -1;
    for (int k = 1; k <= 25; k++) begin
      bus.btn_set_i = (k <= 10);
      tick();
      checks++;
      if (dut_out() !== exp_out()) begin failures++; $display("FAIL set_on k=%0d got=%b exp=%b", k, dut_out(), exp_out()); end
      if (first_on < 0 && bus.time_set_o === 1'b1) first_on = k;
    end
    checks++;
    if (first_on != 6) begin failures++; $display("FAIL set_on_edge got=%0d exp=6", first_on); end
    checks++;
    if (bus.time_set_o !== 1'b1) begin failures++; $display("FAIL set_held got=%b exp=1", bus.time_set_o); end
    for (int k = 1; k <= 25; k++) begin
      bus.btn_set_i = (k <= 10);
      tick();
      checks++;
      if (dut_out() !== exp_out()) begin failures++; $display("FAIL set_off k=%0d got=%b exp=%b", k, dut_out(), exp_out()); end
      if (first_off < 0 && bus.time_set_o === 1'b0) first_off = k;
    end
    checks++;
    if (first_off != 6 || bus.time_set_o !== 1'b0)
      begin failures++; $display("FAIL set_off_edge got=%0d/%b exp=6/0", first_off, bus.time_set_o); end
  endtask

  task automatic test_single_step();
    int cnt = 0;
    int at = -1;
    for (int k = 1; k <= 20; k++) begin
      bus.btn_set_i = (k <= 10);
      tick();
      checks++;
      if (dut_out() !== exp_out()) begin failures++; $display("FAIL single_set k=%0d got=%b exp=%b", k, dut_out(), exp_out()); end
    end
    for (int k = 1; k <= 70; k++) begin
      bus.btn_sec_i = (k <= 5);
      tick();
      checks++;
      if (dut_out() !== exp_out()) begin failures++; $display("FAIL single_step k=%0d got=%b exp=%b", k, dut_out(), exp_out()); end
      if (bus.seconds_id_o === 1'b1) begin cnt++; at = k; end
    end
    checks++;
    if (cnt != 1 || at != 6) begin failures++; $display("FAIL single_pulse got=%0d@%0d exp=1@6", cnt, at); end
  endtask

  task automatic test_repeat();
    int edges[$];
    int exp_e[6] = '{6, 56, 66, 76, 86, 96};
    for (int k = 1; k <= 130; k++) begin
      bus.btn_min_i = (k <= 100);
      tick();
      checks++;
      if (dut_out() !== exp_out()) begin failures++; $display("FAIL repeat k=%0d got=%b exp=%b", k, dut_out(), exp_out()); end
      if (bus.minute_id_o === 1'b1) edges.push_back(k);
    end
    checks++;
    if (edges.size() != 6) begin failures++; $display("FAIL repeat_count got=%0d exp=6", edges.size()); end
    for (int i = 0; i < 6 && i < edges.size(); i++) begin
      checks++;
      if (edges[i] != exp_e[i]) begin failures++; $display("FAIL repeat_edge%0d got=%0d exp=%0d", i, edges[i], exp_e[i]); end
    end
  endtask

  task automatic test_glitch_disabled();
    int cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      bus.btn_hour_i = (k <= 2);
      tick();
      checks++;
      if (dut_out() !== exp_out()) begin failures++; $display("FAIL glitch k=%0d got=%b exp=%b", k, dut_out(), exp_out()); end
      if (bus.hour_id_o === 1'b1) cnt++;
    end
    checks++;
    if (cnt != 0) begin failures++; $display("FAIL glitch_pulse got=%0d exp=0", cnt); end
    for (int k = 1; k <= 20; k++) begin
      bus.btn_set_i = (k <= 10);
      tick();
    end
    cnt = 0;
    for (int k = 1; k <= 60; k++) begin
      bus.btn_hour_i = (k <= 40);
      tick();
      checks++;
      if (dut_out() !== exp_out()) begin failures++; $display("FAIL disabled k=%0d got=%b exp=%b", k, dut_out(), exp_out()); end
      if ({bus.hour_id_o, bus.minute_id_o, bus.seconds_id_o} !== 3'b000) cnt++;
    end
    checks++;
    if (cnt != 0 || bus.time_set_o !== 1'b0)
      begin failures++; $display("FAIL disabled_pulse got=%0d/%b exp=0/0", cnt, bus.time_set_o); end
  endtask

  task automatic test_priority_dir();
    int scnt = 0;
    int ocnt = 0;
    bus.btn_dir_i = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      bus.btn_set_i = (k <= 10);
      tick();
    end
    for (int k = 1; k <= 100; k++) begin
      bus.btn_sec_i  = (k <= 80);
      bus.btn_hour_i = (k <= 80);
      bus.btn_dir_i  = (k < 20);
      tick();
      checks++;
      if (dut_out() !== exp_out()) begin failures++; $display("FAIL prio k=%0d got=%b exp=%b", k, dut_out(), exp_out()); end
      if (bus.seconds_id_o === 1'b1) scnt++;
      if (bus.hour_id_o === 1'b1 || bus.minute_id_o === 1'b1) ocnt++;
      if (k >= 6 && k <= 85) begin
        checks++;
        if (bus.id_switch_o !== 1'b1) begin failures++; $display("FAIL dir_hold k=%0d got=%b exp=1", k, bus.id_switch_o); end
      end
    end
    checks++;
    if (scnt != 4 || ocnt != 0) begin failures++; $display("FAIL prio_pulses got=%0d/%0d exp=4/0", scnt, ocnt); end
    checks++;
    if (bus.id_switch_o !== 1'b0) begin failures++; $display("FAIL dir_idle got=%b exp=0", bus.id_switch_o); end
  endtask

  task automatic test_random();
    logic [2:0] p;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 39) == 0) bus.btn_set_i  = ~bus.btn_set_i;
      if ($urandom_range(0, 29) == 0) bus.btn_dir_i  = ~bus.btn_dir_i;
      if ($urandom_range(0, 14) == 0) bus.btn_hour_i = ~bus.btn_hour_i;
      if ($urandom_range(0, 14) == 0) bus.btn_min_i  = ~bus.btn_min_i;
      if ($urandom_range(0, 14) == 0) bus.btn_sec_i  = ~bus.btn_sec_i;
      tick();
      checks++;
      if (dut_out() !== exp_out()) begin failures++; $display("FAIL random k=%0d got=%b exp=%b", k, dut_out(), exp_out()); end
      p = {bus.hour_id_o, bus.minute_id_o, bus.seconds_id_o};
      checks++;
      if ($countones(p) > 1 || (p != 3'b000 && bus.time_set_o !== 1'b1))
        begin failures++; $display("FAIL pulse_rule k=%0d got=%b ts=%b exp=onehot0 with ts=1", k, p, bus.time_set_o); end
    end
  endtask

  task automatic test_reset_mid();
    set_buttons(0, 0, 0, 0, 0);
    for (int k = 1; k <= 20; k++) tick();
    if (!m_ts) begin
      for (int k = 1; k <= 20; k++) begin
        bus.btn_set_i = (k <= 10);
        tick();
      end
    end
    for (int k = 1; k <= 30; k++) begin
      bus.btn_min_i = 1'b1;
      tick();
      checks++;
      if (dut_out() !== exp_out()) begin failures++; $display("FAIL mid_burst k=%0d got=%b exp=%b", k, dut_out(), exp_out()); end
    end
    #3 reset_i = 1'b1;
    #1;
    model_reset();
    checks++;
    if (dut_out() !== 5'b00000) begin failures++; $display("FAIL reset_async got=%b exp=00000", dut_out()); end
    set_buttons(0, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) tick();
    #4 reset_i = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      checks++;
      if (dut_out() !== 5'b00000 || dut_out() !== exp_out())
        begin failures++; $display("FAIL reset_after k=%0d got=%b exp=00000", k, dut_out()); end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    model_reset();
    test_reset();
    test_set_toggle();
    test_single_step();
    test_repeat();
    test_glitch_disabled();
    test_priority_dir();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
